// File: rtl/capsense_scan_sequencer_if.sv
// Measurement-channel handshake and result-RAM write port of the capacitive
// sensor scan sequencer, grouped so the sequencer and its peers share one bus.
interface capsense_scan_sequencer_if;
    logic        meas_start;
    logic        meas_done;
    logic [15:0] meas_count;
    logic        res_we;
    logic [3:0]  res_addr;
    logic [15:0] res_data;

    modport master (
        output meas_start, res_we, res_addr, res_data,
        input  meas_done, meas_count
    );

    modport slave (
        input  meas_start, res_we, res_addr, res_data,
        output meas_done, meas_count
    );
endinterface

// File: rtl/capsense_scan_sequencer.sv
// Steps through capacitive sensors: settle, measure (with timeout), store, release.
// Optional per-sensor skipping is enabled by defining CAPSNS_SEQ_MASK_EN.
module capsense_scan_sequencer #(
    parameter int NUM_SENSORS    = 8,
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 16'hFFFF
) (
    input  logic                   op_clock,
    input  logic                   reset,
    input  logic                   scan_req,
    input  logic                   abort,
`ifdef CAPSNS_SEQ_MASK_EN
    input  logic [NUM_SENSORS-1:0] sensor_mask,
`endif
    capsense_scan_sequencer_if.master bus,
    output logic [3:0]             sensor_sel,
    output logic                   sensor_en,
    output logic                   busy,
    output logic                   scan_done,
    output logic                   timeout_err
);
    typedef enum logic [2:0] {IDLE, SETTLE, MEAS, STORE, RELEASE, DONE} state_t;

    localparam logic [7:0]  SETTLE_LOAD = 8'(SETTLE_CYCLES);
    localparam logic [15:0] TMO_LAST    = 16'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [7:0]  settle_cnt_q, settle_cnt_d;
    logic [15:0] tmo_cnt_q, tmo_cnt_d;
    logic [15:0] cap_q, cap_d;
    logic        done_prev_q;
    logic [3:0]  sensor_sel_q, sensor_sel_d;
    logic        sensor_en_q, sensor_en_d;
    logic        meas_start_q, meas_start_d;
    logic        res_we_q, res_we_d;
    logic [3:0]  res_addr_q, res_addr_d;
    logic [15:0] res_data_q, res_data_d;
    logic        busy_q, busy_d;
    logic        scan_done_q, scan_done_d;
    logic        timeout_err_q, timeout_err_d;

    logic [NUM_SENSORS-1:0] eff_mask;
    logic [4:0]             first_sns, next_sns;
    logic                   meas_rise;

`ifdef CAPSNS_SEQ_MASK_EN
    assign eff_mask = sensor_mask;
`else
    assign eff_mask = '1;
`endif

    // Lowest enabled sensor at or above 'from'; bit 4 flags that one exists.
    function automatic logic [4:0] find_next(input logic [NUM_SENSORS-1:0] m, input int from);
        logic [4:0] r;
        r = '0;
        for (int i = NUM_SENSORS - 1; i >= 0; i--) begin
            if (i >= from && m[i]) r = {1'b1, 4'(i)};
        end
        return r;
    endfunction

    always_comb begin
        state_d       = state_q;
        settle_cnt_d  = settle_cnt_q;
        tmo_cnt_d     = tmo_cnt_q;
        cap_d         = cap_q;
        sensor_sel_d  = sensor_sel_q;
        sensor_en_d   = sensor_en_q;
        meas_start_d  = meas_start_q;
        res_we_d      = 1'b0;
        res_addr_d    = res_addr_q;
        res_data_d    = res_data_q;
        scan_done_d   = 1'b0;
        timeout_err_d = timeout_err_q;

        first_sns = find_next(eff_mask, 0);
        next_sns  = find_next(eff_mask, int'(sensor_sel_q) + 1);
        // A done level left over from before MEAS entry never counts; only a fresh rise does.
        meas_rise = bus.meas_done && !done_prev_q;

        if (abort && state_q != IDLE) begin
            state_d      = IDLE;
            sensor_sel_d = '0;
            sensor_en_d  = 1'b0;
            meas_start_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (scan_req) begin
                        timeout_err_d = 1'b0;
                        if (first_sns[4]) begin
                            state_d      = SETTLE;
                            sensor_sel_d = first_sns[3:0];
                            settle_cnt_d = SETTLE_LOAD;
                            sensor_en_d  = 1'b1;
                        end else begin
                            state_d     = DONE;
                            scan_done_d = 1'b1;
                        end
                    end
                end
                SETTLE: begin
                    if (settle_cnt_q == 8'd0) begin
                        state_d      = MEAS;
                        meas_start_d = 1'b1;
                        tmo_cnt_d    = '0;
                    end else begin
                        settle_cnt_d = settle_cnt_q - 8'd1;
                    end
                end
                MEAS: begin
                    tmo_cnt_d = tmo_cnt_q + 16'd1;
                    if (meas_rise) begin
                        cap_d        = bus.meas_count;
                        state_d      = STORE;
                        meas_start_d = 1'b0;
                    end else if (tmo_cnt_q == TMO_LAST) begin
                        cap_d         = 16'hFFFF;
                        timeout_err_d = 1'b1;
                        state_d       = STORE;
                        meas_start_d  = 1'b0;
                    end
                end
                // Write is launched on leaving STORE so an abort here suppresses it.
                STORE: begin
                    res_we_d   = 1'b1;
                    res_addr_d = sensor_sel_q;
                    res_data_d = cap_q;
                    state_d    = RELEASE;
                end
                RELEASE: begin
                    if (!bus.meas_done) begin
                        if (next_sns[4]) begin
                            state_d      = SETTLE;
                            sensor_sel_d = next_sns[3:0];
                            settle_cnt_d = SETTLE_LOAD;
                        end else begin
                            state_d     = DONE;
                            sensor_en_d = 1'b0;
                            scan_done_d = 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_d      = IDLE;
                    sensor_sel_d = '0;
                end
                default: state_d = IDLE;
            endcase
        end
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge op_clock) begin
        if (reset) begin
            state_q       <= IDLE;
            settle_cnt_q  <= '0;
            tmo_cnt_q     <= '0;
            cap_q         <= '0;
            done_prev_q   <= 1'b0;
            sensor_sel_q  <= '0;
            sensor_en_q   <= 1'b0;
            meas_start_q  <= 1'b0;
            res_we_q      <= 1'b0;
            res_addr_q    <= '0;
            res_data_q    <= '0;
            busy_q        <= 1'b0;
            scan_done_q   <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            settle_cnt_q  <= settle_cnt_d;
            tmo_cnt_q     <= tmo_cnt_d;
            cap_q         <= cap_d;
            done_prev_q   <= bus.meas_done;
            sensor_sel_q  <= sensor_sel_d;
            sensor_en_q   <= sensor_en_d;
            meas_start_q  <= meas_start_d;
            res_we_q      <= res_we_d;
            res_addr_q    <= res_addr_d;
            res_data_q    <= res_data_d;
            busy_q        <= busy_d;
            scan_done_q   <= scan_done_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign sensor_sel     = sensor_sel_q;
    assign sensor_en      = sensor_en_q;
    assign bus.meas_start = meas_start_q;
    assign bus.res_we     = res_we_q;
    assign bus.res_addr   = res_addr_q;
    assign bus.res_data   = res_data_q;
    assign busy           = busy_q;
    assign scan_done      = scan_done_q;
    assign timeout_err    = timeout_err_q;
endmodule
